sha512_msg_padder: RTL and testbench

Input-side counterpart to the SHA-512/256 digest finalisation stage. Accepts a byte-aligned message as a stream of big-endian 64-bit words. Emits 1024-bit padded SHA-512 blocks (message, 0x80, zeros, 128-bit bit-length) to the compression core, flagging the first block (core loads IV) and the last block (core hands its state to digest finalisation).

---
 rtl/sha512_msg_padder.sv | 219 +++++++++++++++++++++
 tb/tb_sha512_msg_padder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha512_msg_padder.sv
// SHA-512 message padder: packs big-endian 64-bit message words into 1024-bit blocks
// with 0x80 marker, zero fill and 128-bit bit length. Optional abort input: MSG_ABORT_EN.
module sha512_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_data,
  input  logic          in_last,
  input  logic [3:0]    in_bytes,
`ifdef MSG_ABORT_EN
  input  logic          in_abort,
`endif
  output logic          blk_valid,
  input  logic          blk_ready,
  output logic [1023:0] blk_data,
  output logic          blk_first,
  output logic          blk_last
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    BLK  = 2'd1,
    PAD  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [3:0]         wi, wi_nxt;
  logic [LEN_W-1:0]   bit_len, bit_len_nxt;
  logic [LEN_W-1:0]   total_len, total_len_nxt;
  logic               first_pending, first_nxt;
  logic               full_pad, full_pad_nxt;
  logic               blk_valid_nxt, blk_first_nxt, blk_last_nxt;
  logic [1023:0]      blk_data_nxt;
  logic [63:0]        msg_words [15];
  logic               store_word;

  logic               abort;
  logic [3:0]         eff_nb;
  logic [6:0]         nb_bits;
  logic [63:0]        data_mask;
  logic [63:0]        marker;
  logic [7:0]         pad_off;
  logic [LEN_W-1:0]   msg_len;
  logic               fits;
  logic               spill;
  logic [63:0]        word_val;
  logic [1023:0]      assembled;

`ifdef MSG_ABORT_EN
  assign abort = in_abort;
`else
  assign abort = 1'b0;
`endif

  assign in_ready  = (state == FILL);
  assign eff_nb    = in_last ? in_bytes : 4'd8;
  assign nb_bits   = {eff_nb, 3'b000};
  assign data_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> nb_bits);
  // nb=8 shifts the marker out of the current word; spill places it in the next one
  assign marker    = in_last ? (64'h8000_0000_0000_0000 >> nb_bits) : 64'h0;
  assign spill     = in_last & (in_bytes == 4'd8);
  assign pad_off   = {1'b0, wi, 3'b000} + {4'b0000, in_bytes};
  assign msg_len   = bit_len + LEN_W'(nb_bits);
  assign fits      = in_last & (pad_off <= 8'd111);

  // Block image formed from stored words plus the word being accepted now
  always_comb begin
    assembled = 1024'h0;
    word_val  = 64'h0;
    for (int j = 0; j < 16; j++) begin
      if (j < int'(wi)) begin
        word_val = msg_words[j];
      end else if (j == int'(wi)) begin
        word_val = (in_data & data_mask) | marker;
      end else if (spill && (j == int'(wi) + 1)) begin
        word_val = 64'h8000_0000_0000_0000;
      end else begin
        word_val = 64'h0;
      end
      assembled[1023 - 64*j -: 64] = word_val;
    end
    if (fits) begin
      assembled[127:0] = {{(128-LEN_W){1'b0}}, msg_len};
    end else begin
      assembled[127:0] = assembled[127:0];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    wi_nxt        = wi;
    bit_len_nxt   = bit_len;
    total_len_nxt = total_len;
    first_nxt     = first_pending;
    full_pad_nxt  = full_pad;
    blk_valid_nxt = blk_valid;
    blk_data_nxt  = blk_data;
    blk_first_nxt = blk_first;
    blk_last_nxt  = blk_last;
    store_word    = 1'b0;
    case (state)
      FILL: begin
        if (abort) begin
          wi_nxt      = 4'd0;
          bit_len_nxt = {LEN_W{1'b0}};
          first_nxt   = 1'b1;
        end else if (in_valid) begin
          store_word  = (wi != 4'd15);
          bit_len_nxt = msg_len;
          if (in_last) begin
            blk_valid_nxt = 1'b1;
            blk_data_nxt  = assembled;
            blk_first_nxt = first_pending;
            total_len_nxt = msg_len;
            full_pad_nxt  = (pad_off == 8'd128);
            if (fits) begin
              blk_last_nxt = 1'b1;
              state_nxt    = FIN;
            end else begin
              blk_last_nxt = 1'b0;
              state_nxt    = PAD;
            end
          end else if (wi == 4'd15) begin
            blk_valid_nxt = 1'b1;
            blk_data_nxt  = assembled;
            blk_first_nxt = first_pending;
            blk_last_nxt  = 1'b0;
            state_nxt     = BLK;
          end else begin
            wi_nxt = wi + 4'd1;
          end
        end else begin
          state_nxt = FILL;
        end
      end
      BLK: begin
        if (blk_ready) begin
          blk_valid_nxt = 1'b0;
          first_nxt     = 1'b0;
          wi_nxt        = 4'd0;
          state_nxt     = FILL;
        end else begin
          state_nxt = BLK;
        end
      end
      PAD: begin
        if (blk_ready) begin
          blk_data_nxt  = {(full_pad ? 64'h8000_0000_0000_0000 : 64'h0), 832'h0,
                           {(128-LEN_W){1'b0}}, total_len};
          blk_first_nxt = 1'b0;
          blk_last_nxt  = 1'b1;
          state_nxt     = FIN;
        end else begin
          state_nxt = PAD;
        end
      end
      FIN: begin
        if (blk_ready) begin
          blk_valid_nxt = 1'b0;
          wi_nxt        = 4'd0;
          bit_len_nxt   = {LEN_W{1'b0}};
          first_nxt     = 1'b1;
          state_nxt     = FILL;
        end else begin
          state_nxt = FIN;
        end
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wi            <= 4'd0;
      bit_len       <= {LEN_W{1'b0}};
      total_len     <= {LEN_W{1'b0}};
      first_pending <= 1'b1;
      full_pad      <= 1'b0;
      blk_valid     <= 1'b0;
      blk_data      <= 1024'h0;
      blk_first     <= 1'b0;
      blk_last      <= 1'b0;
      for (int k = 0; k < 15; k++) begin
        msg_words[k] <= 64'h0;
      end
    end else begin
      wi            <= wi_nxt;
      bit_len       <= bit_len_nxt;
      total_len     <= total_len_nxt;
      first_pending <= first_nxt;
      full_pad      <= full_pad_nxt;
      blk_valid     <= blk_valid_nxt;
      blk_data      <= blk_data_nxt;
      blk_first     <= blk_first_nxt;
      blk_last      <= blk_last_nxt;
      if (store_word) begin
        msg_words[wi] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_sha512_msg_padder.sv
// Randomized bench for sha512_msg_padder against a byte-level SHA-512 padding model.
module tb_sha512_msg_padder;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_data;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic          blk_valid;
  logic          blk_ready;
  logic [1023:0] blk_data;
  logic          blk_first;
  logic          blk_last;
`ifdef MSG_ABORT_EN
  logic          in_abort = 1'b0;
`endif

  logic [1023:0] exp_q[$];
  logic [1023:0] rx_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sha512_msg_padder dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_bytes(in_bytes),
`ifdef MSG_ABORT_EN
    .in_abort(in_abort),
`endif
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input logic [1023:0] b, input int w);
    return b[1023 - 64*w -: 64];
  endfunction

  // Standard SHA-512 padding done on a byte list, then cut into 128-byte blocks
  task automatic build_expected(input bq_t msg);
    bq_t pad;
    logic [127:0] bits;
    logic [1023:0] blk;
    exp_q.delete();
    pad = msg;
    pad.push_back(8'h80);
    while (pad.size() % 128 != 112) pad.push_back(8'h00);
    bits = 128'(msg.size()) * 128'd8;
    for (int i = 15; i >= 0; i--) pad.push_back(bits[8*i +: 8]);
    for (int b = 0; b < pad.size() / 128; b++) begin
      blk = 1024'h0;
      for (int k = 0; k < 128; k++) blk = {blk[1015:0], pad[b*128 + k]};
      exp_q.push_back(blk);
    end
  endtask

  task automatic send_word(input logic [63:0] d, input bit lst, input int nb, input int gap_max);
    int cnt = 0;
    repeat ($urandom_range(gap_max, 0)) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = lst;
    in_bytes = 4'(nb);
    while (!in_ready && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("in_ready_wait", 128'(cnt < 1000), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input bq_t msg, input bit do_last, input bit zero_tail, input int gap_max);
    int n = msg.size();
    int idx = 0;
    int nb;
    bit lst;
    logic [63:0] d;
    if (n == 0 && do_last) send_word({$urandom, $urandom}, 1'b1, 0, gap_max);
    while (idx < n) begin
      nb  = (n - idx >= 8) ? 8 : n - idx;
      lst = do_last && (idx + nb == n) && !(zero_tail && nb == 8);
      d   = {$urandom, $urandom};
      for (int k = 0; k < nb; k++) d[63 - 8*k -: 8] = msg[idx + k];
      send_word(d, lst, lst ? nb : int'($urandom_range(8, 0)), gap_max);
      idx += nb;
    end
    if (do_last && n > 0 && zero_tail && (n % 8 == 0))
      send_word({$urandom, $urandom}, 1'b1, 0, gap_max);
  endtask

  task automatic collect(input bit rand_ready);
    rx_q.delete();
    for (int b = 0; b < exp_q.size(); b++) begin
      int cnt = 0;
      bit done = 1'b0;
      while (!done && cnt < 2000) begin
        @(negedge clk);
        cnt++;
        if (blk_valid && (!rand_ready || $urandom_range(3, 0) != 0)) begin
          for (int w = 0; w < 16; w++)
            check_eq($sformatf("blk%0d_w%0d", b, w), 128'(word_of(blk_data, w)),
                     128'(word_of(exp_q[b], w)));
          check_eq($sformatf("blk%0d_first", b), 128'(blk_first), 128'(b == 0));
          check_eq($sformatf("blk%0d_last", b), 128'(blk_last), 128'(b == exp_q.size() - 1));
          rx_q.push_back(blk_data);
          blk_ready = 1'b1;
          @(posedge clk);
          #1;
          blk_ready = 1'b0;
          done = 1'b1;
        end
      end
      check_eq("blk_timeout", 128'(done), 128'd1);
    end
    @(negedge clk);
    check_eq("no_extra_blk", 128'(blk_valid), 128'd0);
  endtask

  task automatic run_msg(input bq_t msg, input bit zero_tail, input int gap_max, input bit rand_ready);
    build_expected(msg);
    fork
      send_msg(msg, 1'b1, zero_tail, gap_max);
      collect(rand_ready);
    join
  endtask

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  function automatic logic [1023:0] rx_at(input int i);
    return (rx_q.size() > i) ? rx_q[i] : 1024'h0;
  endfunction

  task automatic check_abc();
    logic [1023:0] r;
    check_eq("abc_nblk", 128'(rx_q.size()), 128'd1);
    r = rx_at(0);
    check_eq("abc_w0", 128'(word_of(r, 0)), 128'h6162638000000000);
    check_eq("abc_w15", 128'(word_of(r, 15)), 128'h18);
    for (int w = 1; w < 15; w++) check_eq($sformatf("abc_w%0d", w), 128'(word_of(r, w)), 128'h0);
  endtask

  initial begin
    bq_t m;
    logic [1023:0] r, s_data;
    logic s_first, s_last;

    reset = 1'b1; in_valid = 1'b0; in_data = 64'h0; in_last = 1'b0;
    in_bytes = 4'd0; blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", 128'(in_ready), 128'd1);
    check_eq("rst_blk_valid", 128'(blk_valid), 128'd0);
    check_eq("rst_blk_first", 128'(blk_first), 128'd0);
    check_eq("rst_blk_last", 128'(blk_last), 128'd0);
    check_eq("rst_blk_data_lo", blk_data[127:0], 128'h0);

    // Empty message
    m = {};
    run_msg(m, 1'b0, 0, 1'b0);
    r = rx_at(0);
    check_eq("empty_nblk", 128'(rx_q.size()), 128'd1);
    check_eq("empty_w0", 128'(word_of(r, 0)), 128'h8000000000000000);
    for (int w = 1; w < 16; w++) check_eq($sformatf("empty_w%0d", w), 128'(word_of(r, w)), 128'h0);

    // "abc"
    m = {8'h61, 8'h62, 8'h63};
    run_msg(m, 1'b0, 0, 1'b0);
    check_abc();

    // 120 bytes: marker lands in word 15, length spills to a second block
    m = rand_bytes(120);
    run_msg(m, 1'b0, 1, 1'b1);
    check_eq("p120_nblk", 128'(rx_q.size()), 128'd2);
    check_eq("p120_b0_w15", 128'(word_of(rx_at(0), 15)), 128'h8000000000000000);
    check_eq("p120_b1_w15", 128'(word_of(rx_at(1), 15)), 128'h3C0);
    check_eq("p120_b1_w0", 128'(word_of(rx_at(1), 0)), 128'h0);

    // 128 bytes with last on the 16th word, under backpressure
    m = rand_bytes(128);
    build_expected(m);
    send_msg(m, 1'b1, 1'b0, 0);
    @(negedge clk);
    check_eq("bp_valid", 128'(blk_valid), 128'd1);
    s_data = blk_data; s_first = blk_first; s_last = blk_last;
    check_eq("bp_first", 128'(s_first), 128'd1);
    check_eq("bp_last", 128'(s_last), 128'd0);
    check_eq("bp_data_w0", 128'(word_of(s_data, 0)), 128'(word_of(exp_q[0], 0)));
    in_valid = 1'b1; in_data = {$urandom, $urandom}; in_last = 1'b0; in_bytes = 4'd8;
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_hold_valid", 128'(blk_valid), 128'd1);
      check_eq("bp_hold_in_ready", 128'(in_ready), 128'd0);
      check_eq("bp_hold_first", 128'(blk_first), 128'(s_first));
      check_eq("bp_hold_last", 128'(blk_last), 128'(s_last));
      for (int w = 0; w < 16; w++)
        check_eq($sformatf("bp_hold_w%0d", w), 128'(word_of(blk_data, w)), 128'(word_of(s_data, w)));
    end
    in_valid = 1'b0;
    collect(1'b0);
    check_eq("p128_b1_w0", 128'(word_of(rx_at(1), 0)), 128'h8000000000000000);
    check_eq("p128_b1_w15", 128'(word_of(rx_at(1), 15)), 128'h400);

    // Reset after 5 partial words, then "abc"
    m = rand_bytes(40);
    send_msg(m, 1'b0, 1'b0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("mrst_valid", 128'(blk_valid), 128'd0);
    check_eq("mrst_in_ready", 128'(in_ready), 128'd1);
    m = {8'h61, 8'h62, 8'h63};
    run_msg(m, 1'b0, 0, 1'b0);
    check_abc();
    check_eq("mrst_first", 128'(rx_q.size() > 0), 128'd1);

    // Random messages with random gaps, backpressure and zero-byte tails
    for (int t = 0; t < 30; t++) begin
      m = rand_bytes($urandom_range(300, 0));
      run_msg(m, 1'($urandom_range(1, 0)), $urandom_range(3, 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
